// File: rtl/uart_cmd_pkg.sv
// uart_cmd_pkg: frame constants, status codes and FSM state encoding for uart_cmd_responder
package uart_cmd_pkg;
    localparam logic [7:0] SOF_REQ   = 8'hA5;
    localparam logic [7:0] SOF_RSP   = 8'h5A;
    localparam logic [7:0] CMD_WR    = 8'h01;
    localparam logic [7:0] CMD_RD    = 8'h02;
    localparam logic [7:0] ST_OK     = 8'h00;
    localparam logic [7:0] ST_BADCHK = 8'h01;
    localparam logic [7:0] ST_BADCMD = 8'h02;
    localparam logic [3:0] S_HUNT      = 4'd0;
    localparam logic [3:0] S_GET_CMD   = 4'd1;
    localparam logic [3:0] S_GET_ADDR  = 4'd2;
    localparam logic [3:0] S_GET_DATA  = 4'd3;
    localparam logic [3:0] S_GET_CHK   = 4'd4;
    localparam logic [3:0] S_EXEC      = 4'd5;
    localparam logic [3:0] S_READ_WAIT = 4'd6;
    localparam logic [3:0] S_SEND      = 4'd7;
    localparam logic [3:0] S_WAIT_HI   = 4'd8;
    localparam logic [3:0] S_WAIT_LO   = 4'd9;
    function automatic logic [7:0] xor3(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c);
        return a ^ b ^ c;
    endfunction
endpackage

// File: rtl/uart_cmd_responder.sv
// uart_cmd_responder: parses 5-byte UART request frames, performs one register read/write, returns a 5-byte response
//   clk, rstn                  clock, async active-low reset
//   rx_data, rx_valid          received byte stream from the UART receiver
//   tx_data, tx_start, tx_busy transmit handshake toward the UART transmitter
//   reg_addr/wdata/we/re/rdata local register bus (rdata valid the cycle after reg_re)
//   busy, frame_ok, frame_err  status: frame in progress, executed, rejected/abandoned
module uart_cmd_responder
    import uart_cmd_pkg::*;
#(
    parameter int TIMEOUT_CYC = 100_000
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic [7:0] rx_data,
    input  logic       rx_valid,
    output logic [7:0] tx_data,
    output logic       tx_start,
    input  logic       tx_busy,
    output logic [7:0] reg_addr,
    output logic [7:0] reg_wdata,
    output logic       reg_we,
    output logic       reg_re,
    input  logic [7:0] reg_rdata,
    output logic       busy,
    output logic       frame_ok,
    output logic       frame_err
);
    localparam int CW = $clog2(TIMEOUT_CYC);

    logic [3:0]    state;
    logic [2:0]    idx;
    logic [CW-1:0] cnt;
    logic [7:0]    cmd, addr, data, chk, status, rdata_q;
    logic          in_get, timeout, chk_bad, cmd_bad, err, sending;

    always_comb begin
        in_get    = state inside {S_GET_CMD, S_GET_ADDR, S_GET_DATA, S_GET_CHK};
        // a byte arriving on the last allowed cycle still counts, so rx_valid wins
        timeout   = in_get && !rx_valid && cnt == CW'(TIMEOUT_CYC - 1);
        chk_bad   = chk != xor3(cmd, addr, data);
        cmd_bad   = cmd != CMD_WR && cmd != CMD_RD;
        err       = chk_bad || cmd_bad;
        sending   = state inside {S_SEND, S_WAIT_HI, S_WAIT_LO};
        // idx is frozen from tx_start until tx_busy falls, so the muxed byte stays stable
        tx_data   = !sending ? 8'h00 :
                    idx == 3'd0 ? SOF_RSP :
                    idx == 3'd1 ? status :
                    idx == 3'd2 ? addr :
                    idx == 3'd3 ? rdata_q : xor3(status, addr, rdata_q);
        tx_start  = state == S_SEND && !tx_busy;
        reg_addr  = addr;
        reg_wdata = data;
        reg_we    = state == S_EXEC && !err && cmd == CMD_WR;
        reg_re    = state == S_EXEC && !err && cmd == CMD_RD;
        busy      = state != S_HUNT;
        frame_ok  = reg_we || state == S_READ_WAIT;
        frame_err = (state == S_EXEC && err) || timeout;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state   <= S_HUNT;
            idx     <= '0;
            cnt     <= '0;
            cmd     <= '0;
            addr    <= '0;
            data    <= '0;
            chk     <= '0;
            status  <= '0;
            rdata_q <= '0;
        end else begin
            cnt <= (in_get && !rx_valid && !timeout) ? cnt + 1'b1 : '0;
            if (timeout) state <= S_HUNT;
            else case (state)
                S_HUNT:      if (rx_valid && rx_data == SOF_REQ) state <= S_GET_CMD;
                S_GET_CMD:   if (rx_valid) begin cmd  <= rx_data; state <= S_GET_ADDR; end
                S_GET_ADDR:  if (rx_valid) begin addr <= rx_data; state <= S_GET_DATA; end
                S_GET_DATA:  if (rx_valid) begin data <= rx_data; state <= S_GET_CHK;  end
                S_GET_CHK:   if (rx_valid) begin chk  <= rx_data; state <= S_EXEC;     end
                S_EXEC: begin
                    status  <= chk_bad ? ST_BADCHK : cmd_bad ? ST_BADCMD : ST_OK;
                    rdata_q <= err ? 8'h00 : data;
                    state   <= (!err && cmd == CMD_RD) ? S_READ_WAIT : S_SEND;
                end
                S_READ_WAIT: begin
                    rdata_q <= reg_rdata;
                    state   <= S_SEND;
                end
                S_SEND:      if (!tx_busy) state <= S_WAIT_HI;
                S_WAIT_HI:   if (tx_busy) state <= S_WAIT_LO;
                S_WAIT_LO:   if (!tx_busy) begin
                    idx   <= idx == 3'd4 ? 3'd0 : idx + 3'd1;
                    state <= idx == 3'd4 ? S_HUNT : S_SEND;
                end
                default:     state <= S_HUNT;
            endcase
        end
    end
endmodule

// File: tb/tb_uart_cmd_responder.sv
// tb_uart_cmd_responder: directed and randomized frames checked against a frame-level reference model
module tb_uart_cmd_responder;
    localparam int TO = 200;

    logic       clk = 0;
    logic       rstn = 0;
    logic [7:0] rx_data = 0;
    logic       rx_valid = 0;
    logic [7:0] tx_data;
    logic       tx_start;
    logic       tx_busy = 0;
    logic [7:0] reg_addr, reg_wdata, reg_rdata;
    logic       reg_we, reg_re, busy, frame_ok, frame_err;

    uart_cmd_responder #(.TIMEOUT_CYC(TO)) dut (
        .clk(clk), .rstn(rstn), .rx_data(rx_data), .rx_valid(rx_valid),
        .tx_data(tx_data), .tx_start(tx_start), .tx_busy(tx_busy),
        .reg_addr(reg_addr), .reg_wdata(reg_wdata), .reg_we(reg_we), .reg_re(reg_re),
        .reg_rdata(reg_rdata), .busy(busy), .frame_ok(frame_ok), .frame_err(frame_err)
    );

    always #5 clk = ~clk;

    int total = 0, bad = 0;
    int hold = 1, tx_cnt = 0;
    logic [7:0] pmem [256];
    logic [7:0] ref_mem [256];

    // peripheral register file
    always @(posedge clk) begin
        if (reg_we) pmem[reg_addr] <= reg_wdata;
        if (reg_re) reg_rdata <= pmem[reg_addr];
    end

    // transmitter: busy for `hold` cycles after each accepted tx_start
    always @(posedge clk) begin
        if (tx_start && !tx_busy) begin
            tx_busy <= 1'b1;
            tx_cnt  <= hold;
        end else if (tx_busy) begin
            if (tx_cnt <= 1) tx_busy <= 1'b0;
            tx_cnt <= tx_cnt - 1;
        end
    end

    int ok_cnt, err_cnt, we_cnt, re_cnt, viol = 0;
    logic [7:0] we_addr, we_data, re_addr, hold_b;
    logic armed = 1, in_fl = 0, prev_busy = 0;
    logic [7:0] txq[$];

    always @(negedge clk) begin
        if (frame_ok) ok_cnt++;
        if (frame_err) err_cnt++;
        if (frame_ok && frame_err) viol++;
        if (reg_we) begin we_cnt++; we_addr = reg_addr; we_data = reg_wdata; end
        if (reg_re) begin re_cnt++; re_addr = reg_addr; end
        if (!rstn) in_fl = 0;
        else if (tx_start) begin
            if (!armed || tx_busy) viol++;
            armed = 0;
            txq.push_back(tx_data);
            hold_b = tx_data;
            in_fl = 1;
        end else if (in_fl && tx_data !== hold_b) viol++;
        if (prev_busy && !tx_busy) begin armed = 1; in_fl = 0; end
        prev_busy = tx_busy;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic clear_mon();
        ok_cnt = 0; err_cnt = 0; we_cnt = 0; re_cnt = 0;
        txq.delete();
    endtask

    task automatic send_byte(input logic [7:0] b);
        @(posedge clk); #1;
        rx_data = b; rx_valid = 1;
        @(posedge clk); #1;
        rx_valid = 0;
        repeat ($urandom_range(0, 3)) @(posedge clk);
    endtask

    task automatic wait_idle(input string tag);
        logic done = 0;
        for (int i = 0; i < 8000 && !done; i++) begin
            @(negedge clk);
            if (!busy) done = 1;
        end
        check({tag, "_idle"}, 32'(done), 1);
    endtask

    task automatic run_frame(input string tag, input logic [7:0] cmd, input logic [7:0] addr,
                             input logic [7:0] data, input logic [7:0] cx);
        logic [7:0] st, rd;
        logic [7:0] ex [5];
        logic wr_ok, rd_ok;
        clear_mon();
        send_byte(8'hA5); send_byte(cmd); send_byte(addr); send_byte(data);
        send_byte(cmd ^ addr ^ data ^ cx);
        st = cx != 0 ? 8'h01 : (cmd == 8'h01 || cmd == 8'h02) ? 8'h00 : 8'h02;
        wr_ok = st == 0 && cmd == 8'h01;
        rd_ok = st == 0 && cmd == 8'h02;
        rd = wr_ok ? data : rd_ok ? ref_mem[addr] : 8'h00;
        if (wr_ok) ref_mem[addr] = data;
        ex = '{8'h5A, st, addr, rd, st ^ addr ^ rd};
        wait_idle(tag);
        check({tag, "_ntx"}, txq.size(), 5);
        for (int i = 0; i < 5; i++)
            check($sformatf("%s_tx%0d", tag, i), i < txq.size() ? 32'(txq[i]) : 32'hxx, 32'(ex[i]));
        check({tag, "_we"}, we_cnt, 32'(wr_ok));
        check({tag, "_re"}, re_cnt, 32'(rd_ok));
        check({tag, "_ok"}, ok_cnt, 32'(st == 0));
        check({tag, "_err"}, err_cnt, 32'(st != 0));
        if (wr_ok) begin
            check({tag, "_waddr"}, 32'(we_addr), 32'(addr));
            check({tag, "_wdata"}, 32'(we_data), 32'(data));
        end
        if (rd_ok) check({tag, "_raddr"}, 32'(re_addr), 32'(addr));
    endtask

    initial begin
        logic [7:0] v, c;
        logic done;
        for (int i = 0; i < 256; i++) begin
            v = 8'($urandom);
            pmem[i] <= v;
            ref_mem[i] = v;
        end
        repeat (3) @(posedge clk);
        #1;
        check("rst_tx_data", 32'(tx_data), 0);
        check("rst_tx_start", 32'(tx_start), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_bus", {reg_addr, reg_wdata, 6'b0, reg_we, reg_re}, 0);
        check("rst_pulses", {frame_ok, frame_err}, 0);
        rstn = 1;
        repeat (2) @(posedge clk);

        run_frame("wr", 8'h01, 8'h10, 8'h3C, 8'h00);
        pmem[8'h10] <= 8'h77;
        ref_mem[8'h10] = 8'h77;
        run_frame("rd", 8'h02, 8'h10, 8'h00, 8'h00);
        run_frame("badchk", 8'h01, 8'h10, 8'h3C, 8'h2D);
        run_frame("badcmd", 8'h07, 8'h20, 8'h55, 8'h00);

        clear_mon();
        send_byte(8'h33); send_byte(8'hA5); send_byte(8'h01);
        repeat (TO + 20) @(posedge clk);
        @(negedge clk);
        check("to_err", err_cnt, 1);
        check("to_ok", ok_cnt, 0);
        check("to_ntx", txq.size(), 0);
        check("to_busy", 32'(busy), 0);
        check("to_bus", we_cnt + re_cnt, 0);
        send_byte(8'h33);
        run_frame("resync", 8'h02, 8'h10, 8'h00, 8'h00);

        for (int n = 0; n < 12; n++) begin
            hold = $urandom_range(1, 6);
            v = 8'($urandom_range(0, 4));
            c = v < 2 ? 8'h01 : v < 4 ? 8'h02 : 8'($urandom);
            run_frame($sformatf("rnd%0d", n), c, 8'($urandom), 8'($urandom),
                      $urandom_range(0, 4) == 0 ? 8'($urandom_range(1, 255)) : 8'h00);
        end

        // backpressure, with a stray SOF byte during the response that must be dropped
        hold = 500;
        fork
            run_frame("bp", 8'h01, 8'h42, 8'h99, 8'h00);
            begin
                done = 0;
                for (int i = 0; i < 2000 && !done; i++) begin
                    @(negedge clk);
                    if (txq.size() >= 1) done = 1;
                end
                send_byte(8'hA5);
            end
        join
        repeat (4) @(negedge clk);
        check("bp_drop_busy", 32'(busy), 0);

        clear_mon();
        send_byte(8'hA5); send_byte(8'h01); send_byte(8'h55); send_byte(8'h66);
        send_byte(8'h01 ^ 8'h55 ^ 8'h66);
        ref_mem[8'h55] = 8'h66;
        done = 0;
        for (int i = 0; i < 3000 && !done; i++) begin
            @(negedge clk);
            if (txq.size() == 2) done = 1;
        end
        check("rst_mid_reach", 32'(done), 1);
        repeat (50) @(posedge clk);
        #1 rstn = 0;
        #1;
        check("rst_mid_busy", 32'(busy), 0);
        check("rst_mid_tx", {24'h0, tx_data}, 0);
        check("rst_mid_start", 32'(tx_start), 0);
        repeat (2) @(posedge clk);
        #1 rstn = 1;
        repeat (1500) @(posedge clk);
        @(negedge clk);
        check("rst_mid_ntx", txq.size(), 2);
        check("rst_mid_idle", 32'(busy), 0);
        check("tx_protocol", viol, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
